// File: rtl/led_pwm_dimmer.sv
// LED PWM dimmer: takes single-cycle pulses from the up, down and on/off
// button edge detectors and drives the LED pin with a glitch-free PWM signal.
// Brightness follows a saturating setpoint and is ramped in and out one step
// per PWM period, so the LED soft-starts and soft-stops.
module led_pwm_dimmer #(
    parameter int CNT_W     = 8,
    parameter int STEP      = 16,
    parameter int INIT_DUTY = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             toggle_i,
    output logic             pwm_o,
    output logic [CNT_W-1:0] level_o,
    output logic             on_o,
    output logic             ramp_o
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DN
    } state_t;

    localparam logic [CNT_W-1:0] MAX_N  = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   MAX_X  = {1'b0, MAX_N};
    localparam logic [CNT_W-1:0] STEP_N = CNT_W'(STEP);
    localparam logic [CNT_W:0]   STEP_X = {1'b0, STEP_N};
    localparam logic [CNT_W-1:0] INIT_N = CNT_W'(INIT_DUTY);

    state_t           state;
    state_t           state_next;
    state_t           state_eff;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] level;
    logic [CNT_W-1:0] level_next;
    logic [CNT_W-1:0] setpoint;
    logic [CNT_W-1:0] setpoint_next;
    logic [CNT_W:0]   level_x;
    logic [CNT_W:0]   setpoint_x;
    logic [CNT_W:0]   up_sum;
    logic [CNT_W:0]   sp_sum;
    logic             pe;

    // The period end marks the only moment the applied level may change, so
    // duty never changes in the middle of a PWM period.
    assign pe         = (cnt == MAX_N);
    assign level_x    = {1'b0, level};
    assign setpoint_x = {1'b0, setpoint};
    assign up_sum     = level_x + STEP_X;
    assign sp_sum     = setpoint_x + STEP_X;

    // Free-running PWM period counter; wraps naturally at the top value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered PWM comparison keeps the LED pin free of decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_o <= 1'b0;
        end else begin
            pwm_o <= (cnt < level);
        end
    end

    // Setpoint arithmetic, saturating at both ends; opposing pulses cancel.
    always_comb begin
        setpoint_next = setpoint;
        if (inc_i && !dec_i) begin
            if (sp_sum > MAX_X) begin
                setpoint_next = MAX_N;
            end else begin
                setpoint_next = sp_sum[CNT_W-1:0];
            end
        end else if (dec_i && !inc_i) begin
            if (setpoint < STEP_N) begin
                setpoint_next = '0;
            end else begin
                setpoint_next = setpoint - STEP_N;
            end
        end
    end

    // Setpoint register; it keeps moving while the LED is off so the new
    // value is picked up at the next switch-on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setpoint <= INIT_N;
        end else begin
            setpoint <= setpoint_next;
        end
    end

    // Ramp FSM: a toggle is applied first, then a period end updates the
    // level using the rule of the state just entered.
    always_comb begin
        state_eff = state;
        if (toggle_i) begin
            case (state)
                ST_OFF:     state_eff = ST_RAMP_UP;
                ST_RAMP_UP: state_eff = ST_RAMP_DN;
                ST_ON:      state_eff = ST_RAMP_DN;
                ST_RAMP_DN: state_eff = ST_RAMP_UP;
                default:    state_eff = ST_OFF;
            endcase
        end

        state_next = state_eff;
        level_next = level;

        if (pe) begin
            case (state_eff)
                ST_OFF: begin
                    level_next = '0;
                end
                ST_RAMP_UP: begin
                    if (up_sum >= setpoint_x) begin
                        level_next = setpoint;
                        state_next = ST_ON;
                    end else begin
                        level_next = up_sum[CNT_W-1:0];
                    end
                end
                ST_ON: begin
                    level_next = setpoint;
                end
                ST_RAMP_DN: begin
                    if (level_x <= STEP_X) begin
                        level_next = '0;
                        state_next = ST_OFF;
                    end else begin
                        level_next = level - STEP_N;
                    end
                end
                default: begin
                    level_next = '0;
                    state_next = ST_OFF;
                end
            endcase
        end
    end

    // State and applied-level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            level <= '0;
        end else begin
            state <= state_next;
            level <= level_next;
        end
    end

    // Status outputs decoded straight from the registered state.
    assign level_o = level;
    assign on_o    = (state != ST_OFF);
    assign ramp_o  = (state == ST_RAMP_UP) || (state == ST_RAMP_DN);

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Self-checking bench for led_pwm_dimmer: directed scenarios followed by
// random button traffic, all compared against an integer-level model.
module tb_led_pwm_dimmer;

    localparam int CNT_W     = 4;
    localparam int STEP      = 4;
    localparam int INIT_DUTY = 8;
    localparam int PERIOD    = 1 << CNT_W;
    localparam int MAXV      = PERIOD - 1;

    logic             clk;
    logic             rst;
    logic             inc_i;
    logic             dec_i;
    logic             toggle_i;
    logic             pwm_o;
    logic [CNT_W-1:0] level_o;
    logic             on_o;
    logic             ramp_o;

    int    n_checks;
    int    n_fail;

    int    m_cnt;
    int    m_level;
    int    m_sp;
    int    m_pwm;
    string m_mode;
    bit    m_just_pe;

    led_pwm_dimmer #(
        .CNT_W(CNT_W),
        .STEP(STEP),
        .INIT_DUTY(INIT_DUTY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inc_i(inc_i),
        .dec_i(dec_i),
        .toggle_i(toggle_i),
        .pwm_o(pwm_o),
        .level_o(level_o),
        .on_o(on_o),
        .ramp_o(ramp_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_cnt     = 0;
        m_level   = 0;
        m_sp      = INIT_DUTY;
        m_pwm     = 0;
        m_mode    = "OFF";
        m_just_pe = 1'b0;
    endtask

    // One clock of the behavioural model, driven by the pulses seen at the edge.
    task automatic modelStep(input bit inc, input bit dec, input bit tog);
        bit    pe;
        string mode;
        int    nl;
        pe    = (m_cnt == MAXV);
        m_pwm = (m_cnt < m_level) ? 1 : 0;
        mode  = m_mode;
        if (tog) begin
            if (mode == "OFF" || mode == "DN") mode = "UP";
            else mode = "DN";
        end
        if (pe) begin
            if (mode == "UP") begin
                nl = m_level + STEP;
                if (nl >= m_sp) begin
                    m_level = m_sp;
                    mode    = "ON";
                end else begin
                    m_level = nl;
                end
            end else if (mode == "ON") begin
                m_level = m_sp;
            end else if (mode == "DN") begin
                nl = m_level - STEP;
                if (nl <= 0) begin
                    m_level = 0;
                    mode    = "OFF";
                end else begin
                    m_level = nl;
                end
            end else begin
                m_level = 0;
            end
        end
        m_mode    = mode;
        m_just_pe = pe;
        m_cnt     = (m_cnt + 1) % PERIOD;
        if (inc && !dec) m_sp = (m_sp + STEP > MAXV) ? MAXV : m_sp + STEP;
        else if (dec && !inc) m_sp = (m_sp < STEP) ? 0 : m_sp - STEP;
    endtask

    task automatic compareModel();
        checkOutput("pwm", int'(pwm_o), m_pwm);
        checkOutput("level", int'(level_o), m_level);
        checkOutput("on", int'(on_o), (m_mode != "OFF") ? 1 : 0);
        checkOutput("ramp", int'(ramp_o), (m_mode == "UP" || m_mode == "DN") ? 1 : 0);
    endtask

    // Drive one cycle of pulses, step the model and compare after the edge.
    task automatic applyStimulus(input bit inc, input bit dec, input bit tog);
        inc_i    = inc;
        dec_i    = dec;
        toggle_i = tog;
        @(posedge clk);
        modelStep(inc, dec, tog);
        #2;
        compareModel();
        inc_i    = 1'b0;
        dec_i    = 1'b0;
        toggle_i = 1'b0;
    endtask

    task automatic runToPe();
        for (int i = 0; i < 2 * PERIOD; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (m_just_pe) break;
        end
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must
    // clear before the next edge arrives.
    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_pwm", int'(pwm_o), 0);
        checkOutput("rst_level", int'(level_o), 0);
        checkOutput("rst_on", int'(on_o), 0);
        checkOutput("rst_ramp", int'(ramp_o), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int highs;
        int r;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        inc_i    = 1'b0;
        dec_i    = 1'b0;
        toggle_i = 1'b0;
        modelReset();
        doReset();

        // Reset in the middle of a ramp, then confirm the LED stays dark.
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        doReset();
        highs = 0;
        for (int i = 0; i < 5 * PERIOD; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            highs += int'(pwm_o);
        end
        checkOutput("dark_after_rst", highs, 0);

        // Soft start to the initial setpoint.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("start_ramp", int'(ramp_o), 1);
        runToPe();
        checkOutput("start_lvl1", int'(level_o), 4);
        runToPe();
        checkOutput("start_lvl2", int'(level_o), 8);
        checkOutput("start_on", int'(on_o), 1);
        checkOutput("start_ramp_done", int'(ramp_o), 0);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            highs += int'(pwm_o);
        end
        checkOutput("duty8", highs, 8);

        // Setpoint saturation while ON.
        applyStimulus(1'b1, 1'b0, 1'b0);
        runToPe();
        checkOutput("inc_lvl12", int'(level_o), 12);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runToPe();
        checkOutput("inc_lvl15", int'(level_o), 15);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            highs += int'(pwm_o);
        end
        checkOutput("duty_max", highs, PERIOD - 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        runToPe();
        checkOutput("dec_lvl0", int'(level_o), 0);
        checkOutput("on_at_zero", int'(on_o), 1);

        // Back to 8, then opposing pulses must not disturb the period.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runToPe();
        checkOutput("back_lvl8", int'(level_o), 8);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            applyStimulus(i < 3, i < 3, 1'b0);
            highs += int'(pwm_o);
            checkOutput("hold8", int'(level_o), 8);
        end
        checkOutput("hold_duty", highs, 8);

        // Soft stop interrupted by a reversal.
        applyStimulus(1'b0, 1'b0, 1'b1);
        runToPe();
        checkOutput("stop_lvl4", int'(level_o), 4);
        checkOutput("stop_ramp", int'(ramp_o), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runToPe();
        checkOutput("rev_lvl8", int'(level_o), 8);
        checkOutput("rev_on", int'(on_o), 1);
        checkOutput("rev_ramp", int'(ramp_o), 0);

        // Full stop, then a toggle landing exactly on the period-end cycle.
        applyStimulus(1'b0, 1'b0, 1'b1);
        runToPe();
        runToPe();
        checkOutput("off_lvl", int'(level_o), 0);
        checkOutput("off_on", int'(on_o), 0);
        for (int i = 0; i < PERIOD - 1; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pe_tog_lvl", int'(level_o), 4);
        checkOutput("pe_tog_ramp", int'(ramp_o), 1);

        // Switch-on with a zero setpoint lands in ON with a dark LED.
        applyStimulus(1'b0, 1'b0, 1'b1);
        runToPe();
        checkOutput("off2_on", int'(on_o), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runToPe();
        checkOutput("zero_on", int'(on_o), 1);
        checkOutput("zero_ramp", int'(ramp_o), 0);
        checkOutput("zero_lvl", int'(level_o), 0);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            highs += int'(pwm_o);
        end
        checkOutput("zero_duty", highs, 0);

        // Random button traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                doReset();
            end else if (r < 12) begin
                applyStimulus(1'b1, 1'b0, 1'b0);
            end else if (r < 22) begin
                applyStimulus(1'b0, 1'b1, 1'b0);
            end else if (r < 26) begin
                applyStimulus(1'b1, 1'b1, 1'b0);
            end else if (r < 30) begin
                applyStimulus(1'b0, 1'b0, 1'b1);
            end else if (r < 32) begin
                applyStimulus(1'b1, 1'b0, 1'b1);
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
